// File: rtl/data_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder_pkg
// Purpose  : Shared state encodings and word-address helpers for the
//            MEM-stage data memory responder.
// Revision : 1.0 - initial release
// ============================================================================
package data_mem_responder_pkg;

    // Responder states, encoded to match the mem_stage naming.
    localparam logic [1:0] c_IDLE       = 2'b00;
    localparam logic [1:0] c_READ_WAIT  = 2'b01;
    localparam logic [1:0] c_WRITE_WAIT = 2'b10;

    // Byte addresses carry two byte-offset bits below the word index.
    localparam int c_WORD_LSB   = 2;
    localparam int c_DATA_W     = 32;
    localparam int c_BUS_ADDR_W = 32;

    // True when any address bit above the word index of the RAM is set.
    function automatic logic addr_out_of_range(input logic [c_BUS_ADDR_W-1:0] addr,
                                               input int addr_width);
        return (addr >> (addr_width + c_WORD_LSB)) != '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder_if
// Purpose  : MEM-stage memory request/ack bus between initiator (master)
//            and data memory responder (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface data_mem_responder_if;
    import data_mem_responder_pkg::*;

    logic                    mem_read_req;
    logic [c_BUS_ADDR_W-1:0] mem_read_addr;
    logic [c_DATA_W-1:0]     mem_read_data;
    logic                    mem_read_ack;
    logic                    mem_write_req;
    logic [c_BUS_ADDR_W-1:0] mem_write_addr;
    logic [c_DATA_W-1:0]     mem_write_data;
    logic                    mem_write_ack;
    logic                    busy;
    logic                    protocol_err;

    modport master (
        output mem_read_req, mem_read_addr,
        output mem_write_req, mem_write_addr, mem_write_data,
        input  mem_read_data, mem_read_ack, mem_write_ack, busy, protocol_err
    );

    modport slave (
        input  mem_read_req, mem_read_addr,
        input  mem_write_req, mem_write_addr, mem_write_data,
        output mem_read_data, mem_read_ack, mem_write_ack, busy, protocol_err
    );

endinterface
`default_nettype wire

// File: rtl/data_mem_responder_dmem_ram.sv
`default_nettype none
// ============================================================================
// Module   : dmem_ram
// Purpose  : Single-port synchronous RAM, one read or one write per cycle.
//            Contents are not reset.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_ram #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  wire logic                  clk,
    input  wire logic                  i_en,
    input  wire logic                  i_we,
    input  wire logic [ADDR_WIDTH-1:0] i_addr,
    input  wire logic [DATA_WIDTH-1:0] i_wdata,
    output logic      [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [0:(2**ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] r_q;

    // Write the addressed word, or register its contents for a read.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end else begin
                r_q <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_q;

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Purpose  : Responder end of the MEM-stage memory interface. Services
//            single-word read/write requests against an internal RAM and
//            returns a one-cycle ack after a fixed latency.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH    = 10,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 1
) (
    input wire logic           clk,
    input wire logic           reset,
    data_mem_responder_if.slave bus
);

    localparam int c_MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int c_CNT_W   = $clog2(c_MAX_LAT) + 1;
    localparam logic [c_CNT_W-1:0] c_RD_LOAD = c_CNT_W'(READ_LATENCY - 1);
    localparam logic [c_CNT_W-1:0] c_WR_LOAD = c_CNT_W'(WRITE_LATENCY - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    logic [1:0]            r_state, w_state_nxt;
    logic [c_CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [ADDR_WIDTH-1:0] r_index, w_index_nxt;
    logic [c_DATA_W-1:0]   r_wdata, w_wdata_nxt;
    logic                  r_oor, w_oor_nxt;
    logic                  r_protocol_err, w_err_nxt;
    logic [c_DATA_W-1:0]   r_read_data;

    logic                  w_read_ack, w_write_ack;
    logic                  w_ram_en, w_ram_we;
    logic [ADDR_WIDTH-1:0] w_ram_addr;
    logic [c_DATA_W-1:0]   w_ram_q;
    logic [c_DATA_W-1:0]   w_rd_out;

    logic [ADDR_WIDTH-1:0] w_rd_index, w_wr_index;
    logic                  w_rd_oor, w_wr_oor, w_rd_mis, w_wr_mis, w_any_req;

    assign w_rd_index = bus.mem_read_addr[ADDR_WIDTH+1:c_WORD_LSB];
    assign w_wr_index = bus.mem_write_addr[ADDR_WIDTH+1:c_WORD_LSB];
    assign w_rd_oor   = addr_out_of_range(bus.mem_read_addr, ADDR_WIDTH);
    assign w_wr_oor   = addr_out_of_range(bus.mem_write_addr, ADDR_WIDTH);
    assign w_rd_mis   = |bus.mem_read_addr[c_WORD_LSB-1:0];
    assign w_wr_mis   = |bus.mem_write_addr[c_WORD_LSB-1:0];
    assign w_any_req  = bus.mem_read_req | bus.mem_write_req;

    // Next-state, latency countdown, RAM port control and acks.
    // The RAM read is launched one edge before the ack cycle so the word is
    // on the RAM output during the ack; for a one-cycle read latency that
    // edge is the request sampling edge itself.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_index_nxt = r_index;
        w_wdata_nxt = r_wdata;
        w_oor_nxt   = r_oor;
        w_err_nxt   = r_protocol_err;
        w_ram_en    = 1'b0;
        w_ram_we    = 1'b0;
        w_ram_addr  = r_index;
        w_read_ack  = 1'b0;
        w_write_ack = 1'b0;

        case (r_state)
            c_IDLE: begin
                if (bus.mem_read_req) begin
                    w_index_nxt = w_rd_index;
                    w_oor_nxt   = w_rd_oor;
                    w_cnt_nxt   = c_RD_LOAD;
                    w_state_nxt = c_READ_WAIT;
                    // A simultaneous write is dropped in favour of the read.
                    if (bus.mem_write_req || w_rd_mis || w_rd_oor) begin
                        w_err_nxt = 1'b1;
                    end
                    if (READ_LATENCY == 1) begin
                        w_ram_en   = 1'b1;
                        w_ram_addr = w_rd_index;
                    end
                end else if (bus.mem_write_req) begin
                    w_index_nxt = w_wr_index;
                    w_wdata_nxt = bus.mem_write_data;
                    w_oor_nxt   = w_wr_oor;
                    w_cnt_nxt   = c_WR_LOAD;
                    w_state_nxt = c_WRITE_WAIT;
                    if (w_wr_mis || w_wr_oor) begin
                        w_err_nxt = 1'b1;
                    end
                end
            end

            c_READ_WAIT: begin
                if (w_any_req) begin
                    w_err_nxt = 1'b1;
                end
                if (r_cnt == '0) begin
                    w_read_ack  = 1'b1;
                    w_state_nxt = c_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                    if (r_cnt == c_CNT_ONE) begin
                        w_ram_en = 1'b1;
                    end
                end
            end

            c_WRITE_WAIT: begin
                if (w_any_req) begin
                    w_err_nxt = 1'b1;
                end
                if (r_cnt == '0) begin
                    w_write_ack = 1'b1;
                    w_state_nxt = c_IDLE;
                    // Commit at the edge closing the ack; out-of-range writes vanish.
                    w_ram_en    = ~r_oor;
                    w_ram_we    = ~r_oor;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end

            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Control registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= c_IDLE;
            r_cnt          <= '0;
            r_index        <= '0;
            r_wdata        <= '0;
            r_oor          <= 1'b0;
            r_protocol_err <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_index        <= w_index_nxt;
            r_wdata        <= w_wdata_nxt;
            r_oor          <= w_oor_nxt;
            r_protocol_err <= w_err_nxt;
        end
    end

    // Out-of-range reads return zero instead of the aliased RAM word.
    assign w_rd_out = r_oor ? '0 : w_ram_q;

    // Hold the last returned read word until the next read ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_read_data <= '0;
        end else if (w_read_ack) begin
            r_read_data <= w_rd_out;
        end
    end

    dmem_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (c_DATA_W)
    ) u_dmem_ram (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (r_wdata),
        .o_rdata (w_ram_q)
    );

    assign bus.mem_read_data = w_read_ack ? w_rd_out : r_read_data;
    assign bus.mem_read_ack  = w_read_ack;
    assign bus.mem_write_ack = w_write_ack;
    assign bus.busy          = (r_state != c_IDLE);
    assign bus.protocol_err  = r_protocol_err;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Purpose  : Self-checking bench for data_mem_responder; runs a default
//            latency instance and a 4/3 latency instance side by side.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic reset;

    data_mem_responder_if bus0 ();
    data_mem_responder_if bus1 ();

    data_mem_responder u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    data_mem_responder #(
        .ADDR_WIDTH    (10),
        .READ_LATENCY  (4),
        .WRITE_LATENCY (3)
    ) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: word memory, sticky error flag, last returned read word.
    logic [31:0] mdl_mem [0:1023];
    bit          mdl_err;
    logic [31:0] mdl_rdata;

    // Per-transaction observations for each instance.
    int          fr [2];
    int          nr [2];
    int          fw [2];
    int          nw [2];
    int          nb [2];
    logic [31:0] dat [2];

    function automatic int exp_rl(input int d);
        return (d == 0) ? 2 : 4;
    endfunction

    function automatic int exp_wl(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wd);
        bus0.mem_read_req   = rd;
        bus0.mem_read_addr  = addr;
        bus0.mem_write_req  = wr;
        bus0.mem_write_addr = addr;
        bus0.mem_write_data = wd;
        bus1.mem_read_req   = rd;
        bus1.mem_read_addr  = addr;
        bus1.mem_write_req  = wr;
        bus1.mem_write_addr = addr;
        bus1.mem_write_data = wd;
    endtask

    task automatic sample(input int k);
        if (bus0.mem_read_ack) begin
            nr[0]++;
            if (fr[0] == 0) begin fr[0] = k; dat[0] = bus0.mem_read_data; end
        end
        if (bus0.mem_write_ack) begin nw[0]++; if (fw[0] == 0) fw[0] = k; end
        if (bus0.busy) nb[0]++;
        if (bus1.mem_read_ack) begin
            nr[1]++;
            if (fr[1] == 0) begin fr[1] = k; dat[1] = bus1.mem_read_data; end
        end
        if (bus1.mem_write_ack) begin nw[1]++; if (fw[1] == 0) fw[1] = k; end
        if (bus1.busy) nb[1]++;
    endtask

    task automatic check_quiet(input string name);
        check({name, " d0 rack"}, 32'(bus0.mem_read_ack), 32'd0);
        check({name, " d0 wack"}, 32'(bus0.mem_write_ack), 32'd0);
        check({name, " d0 busy"}, 32'(bus0.busy), 32'd0);
        check({name, " d0 err"}, 32'(bus0.protocol_err), 32'd0);
        check({name, " d0 rdata"}, bus0.mem_read_data, 32'd0);
        check({name, " d1 rack"}, 32'(bus1.mem_read_ack), 32'd0);
        check({name, " d1 wack"}, 32'(bus1.mem_write_ack), 32'd0);
        check({name, " d1 busy"}, 32'(bus1.busy), 32'd0);
        check({name, " d1 err"}, 32'(bus1.protocol_err), 32'd0);
        check({name, " d1 rdata"}, bus1.mem_read_data, 32'd0);
    endtask

    // One request (read, write or both) plus an optional write pulse the
    // cycle after, which must be rejected as the responder is then busy.
    task automatic txn(input string name, input bit rd, input bit wr,
                       input logic [31:0] addr, input logic [31:0] wd, input bit late_wr);
        logic [31:0] exp_d;
        bit          oor;
        bit          mis;
        int          idx;
        for (int d = 0; d < 2; d++) begin
            fr[d] = 0; nr[d] = 0; fw[d] = 0; nw[d] = 0; nb[d] = 0; dat[d] = '0;
        end
        @(negedge clk);
        drive(rd, wr, addr, wd);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            sample(k);
            if (k == 1) drive(1'b0, late_wr, addr, wd);
            else        drive(1'b0, 1'b0, addr, wd);
        end

        oor   = (addr >= 32'h0000_1000);
        mis   = (addr[1:0] != 2'b00);
        idx   = int'(addr[11:2]);
        exp_d = oor ? 32'd0 : mdl_mem[idx];
        if ((rd || wr) && (oor || mis)) mdl_err = 1'b1;
        if (rd && wr) mdl_err = 1'b1;
        if (late_wr) mdl_err = 1'b1;

        for (int d = 0; d < 2; d++) begin
            if (rd) begin
                check($sformatf("%s d%0d read ack cycle", name, d), 32'(fr[d]), 32'(exp_rl(d)));
                check($sformatf("%s d%0d read ack count", name, d), 32'(nr[d]), 32'd1);
                check($sformatf("%s d%0d write ack count", name, d), 32'(nw[d]), 32'd0);
                check($sformatf("%s d%0d busy cycles", name, d), 32'(nb[d]), 32'(exp_rl(d)));
                check($sformatf("%s d%0d read data", name, d), dat[d], exp_d);
            end else if (wr) begin
                check($sformatf("%s d%0d write ack cycle", name, d), 32'(fw[d]), 32'(exp_wl(d)));
                check($sformatf("%s d%0d write ack count", name, d), 32'(nw[d]), 32'd1);
                check($sformatf("%s d%0d read ack count", name, d), 32'(nr[d]), 32'd0);
                check($sformatf("%s d%0d busy cycles", name, d), 32'(nb[d]), 32'(exp_wl(d)));
            end
        end

        if (rd) mdl_rdata = exp_d;
        else if (wr && !oor) mdl_mem[idx] = wd;

        check({name, " d0 held rdata"}, bus0.mem_read_data, mdl_rdata);
        check({name, " d1 held rdata"}, bus1.mem_read_data, mdl_rdata);
        check({name, " d0 err"}, 32'(bus0.protocol_err), 32'(mdl_err));
        check({name, " d1 err"}, 32'(bus1.protocol_err), 32'(mdl_err));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        mdl_err   = 1'b0;
        mdl_rdata = '0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int          nacks;
        int          op;
        bit          rd;
        bit          wr;
        bit          lw;
        logic [31:0] a;

        reset     = 1'b0;
        mdl_err   = 1'b0;
        mdl_rdata = '0;
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        check_quiet("reset");
        reset = 1'b1;

        // Give every word the random traffic can reach a known value.
        for (int w = 0; w < 64; w++) begin
            txn("init", 1'b0, 1'b1, 32'(w * 4), $urandom, 1'b0);
        end
        txn("init_top", 1'b0, 1'b1, 32'h0000_0FFC, $urandom, 1'b0);

        txn("wr_0x10", 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        txn("rd_0x10", 1'b1, 1'b0, 32'h0000_0010, 32'd0, 1'b0);
        txn("wr_top", 1'b0, 1'b1, 32'h0000_0FFC, 32'hA5A5_0FFC, 1'b0);
        txn("rd_top", 1'b1, 1'b0, 32'h0000_0FFC, 32'd0, 1'b0);
        txn("rd_oor", 1'b1, 1'b0, 32'h0000_1000, 32'd0, 1'b0);
        txn("wr_oor", 1'b0, 1'b1, 32'h0000_2000, 32'h1111_2222, 1'b0);
        txn("rd_word0", 1'b1, 1'b0, 32'h0000_0000, 32'd0, 1'b0);
        pulse_reset();
        txn("rd_mis", 1'b1, 1'b0, 32'h0000_0003, 32'd0, 1'b0);

        // Reset while the default instance sits in its ack cycle.
        pulse_reset();
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0000_0010, 32'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0000_0010, 32'd0);
        check("rst_mid d1 busy", 32'(bus1.busy), 32'd1);
        @(negedge clk);
        check("rst_mid d0 ack before", 32'(bus0.mem_read_ack), 32'd1);
        reset = 1'b0;
        #1;
        check_quiet("rst_mid");
        @(negedge clk);
        reset = 1'b1;
        nacks = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus0.mem_read_ack || bus1.mem_read_ack || bus0.mem_write_ack || bus1.mem_write_ack) nacks++;
        end
        check("rst_mid no late ack", 32'(nacks), 32'd0);
        txn("rd_after_rst", 1'b1, 1'b0, 32'h0000_0010, 32'd0, 1'b0);

        txn("busy_reject", 1'b1, 1'b0, 32'h0000_0020, 32'h1234_5678, 1'b1);
        txn("rd_0x20_after", 1'b1, 1'b0, 32'h0000_0020, 32'd0, 1'b0);
        pulse_reset();
        txn("simul", 1'b1, 1'b1, 32'h0000_0030, 32'hCAFE_F00D, 1'b0);
        txn("rd_0x30_after", 1'b1, 1'b0, 32'h0000_0030, 32'd0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            a  = 32'($urandom_range(0, 255));
            op = $urandom_range(0, 3);
            rd = (op == 0) || (op == 3);
            wr = (op >= 1);
            lw = rd && !wr && ($urandom_range(0, 5) == 0);
            txn($sformatf("rand%0d", i), rd, wr, a, $urandom, lw);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the MEM-stage memory interface: accepts single-word read/write requests from the initiator, services them against an internal word-addressed RAM, and returns a one-cycle ack after a parameterised latency.
- Read data is returned with the ack.
- Sits between mem_stage and the data-memory model; serves as the simulation/FPGA data memory for the pipeline.

Parameters:
- ADDR_WIDTH, 10, word-index bits; depth = 2**ADDR_WIDTH words of 32 bits.
- READ_LATENCY, 2, cycles from the request sampling edge to the ack cycle; must be >= 1.
- WRITE_LATENCY, 1, same for writes; must be >= 1.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- mem_read_req  input  1  read request pulse.
- mem_read_addr  input  32  byte address of read.
- mem_read_data  output  32  read data, valid in ack cycle, held until next read ack.
- mem_read_ack  output  1  one-cycle read completion pulse.
- mem_write_req  input  1  write request pulse.
- mem_write_addr  input  32  byte address of write.
- mem_write_data  input  32  write data.
- mem_write_ack  output  1  one-cycle write completion pulse.
- busy  output  1  high while a request is outstanding (state != IDLE).
- protocol_err  output  1  sticky; set on any ignored or malformed request.

Behaviour:
- Reset (reset=0, async) forces:
  - state=IDLE, mem_read_data=0, both acks=0, busy=0, protocol_err=0, latency counter=0.
  - RAM contents are not reset.
- States: IDLE, READ_WAIT, WRITE_WAIT.
- IDLE:
  - Samples requests each edge.
  - mem_read_req=1: latch word index addr[ADDR_WIDTH+1:2]; set cnt=READ_LATENCY-1; go to READ_WAIT.
  - mem_write_req=1 (no read): latch index and data; set cnt=WRITE_LATENCY-1; go to WRITE_WAIT.
  - Both high in the same cycle: read is accepted, write is dropped, protocol_err set.
- READ_WAIT / WRITE_WAIT:
  - cnt decrements each cycle.
  - When cnt==0, the corresponding ack is driven high for exactly that cycle and state returns to IDLE at the next edge.
  - Ack rises L cycles after the sampling edge (L=1 means ack in the cycle right after the request).
- Read path: mem_read_data is registered with RAM[index], updated only when mem_read_ack is asserted.
- Write path: the RAM is written at the edge that ends the ack cycle. A read of the same word accepted afterwards returns the new data.
- Requests seen while state != IDLE, including the ack cycle, are ignored, no ack is given, and protocol_err is set.
- Requests are pulses: a req held high for N idle cycles starts N back-to-back transactions, each re-sampled on IDLE return.
- Misaligned address (addr[1:0] != 0): bits ignored, transaction proceeds, protocol_err set.
- Out-of-range address (any bit above ADDR_WIDTH+1 set):
  - Read returns 32'h00000000.
  - Write is discarded.
  - Ack is still given; protocol_err is set.
- Async reset mid-transaction aborts it: no ack is issued, and a write not yet committed is lost.
- busy = (state != IDLE); it is combinational from the state register.

Decomposition:
- Shared package/include: state encodings (IDLE=2'b00, READ_WAIT=2'b01, WRITE_WAIT=2'b10, matching mem_stage naming) and the word-address slice constant.
- One sub-module, dmem_ram: single-port 32-bit synchronous RAM (one read or one write per cycle, no reset), instantiated by the responder FSM.

Test Plan:
- Write then read, defaults: write addr 0x10 data 0xDEADBEEF, then read 0x10.
  - mem_write_ack 1 cycle after req.
  - mem_read_ack 2 cycles after read req, with mem_read_data=0xDEADBEEF.
  - protocol_err=0.
- Latency sweep: READ_LATENCY=4, WRITE_LATENCY=3 -> acks on exactly the 4th/3rd cycle after sampling; busy high for those cycles.
- Busy rejection: read 0x20, then write pulse 1 cycle later -> only the read is acked, RAM[0x20] unchanged, protocol_err=1 and remains set.
- Simultaneous req: read and write both pulsed at 0x30 -> read ack only, returning the old RAM[0x30]; write dropped; protocol_err=1.
- Boundary addresses:
  - Write/read at word 1023 (0xFFC) succeeds.
  - Read at 0x1000 acks with data 0 and sets protocol_err.
  - Read at 0x3 acks with RAM[0] and sets protocol_err.
- Reset mid-read: assert reset (low) during READ_WAIT -> acks drop immediately, mem_read_data=0, state IDLE; a fresh read after release completes normally.
